digi_pattern_source: RTL

//  Programmable digital stimulus sequencer, the qucsator DigiSource equivalent.

---
 rtl/digi_pattern_source_if.sv | 32 +++
 rtl/digi_pattern_source.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/digi_pattern_source_if.sv
// Control, table-write and playout-status bundle for digi_pattern_source.
// master drives requests (wrapper/bench); slave is the sequencer itself.
interface digi_pattern_source_if #(
    parameter int DEPTH = 8,
    parameter int DUR_W = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             wr_valid;
    logic             wr_ready;
    logic             wr_level;
    logic [DUR_W-1:0] wr_dur;
    logic             clear;
    logic             start;
    logic             stop;
    logic             repeat_en;
    logic             dout;
    logic             edge_o;
    logic             busy;
    logic             done;
    logic [CW-1:0]    count;

    modport master (
        output wr_valid, wr_level, wr_dur, clear, start, stop, repeat_en,
        input  wr_ready, dout, edge_o, busy, done, count
    );

    modport slave (
        input  wr_valid, wr_level, wr_dur, clear, start, stop, repeat_en,
        output wr_ready, dout, edge_o, busy, done, count
    );
endinterface

// File: rtl/digi_pattern_source.sv
// Plays a (level, duration) table on a registered 1-bit line; dout follows start by 1 cycle.
// Table writes are refused (wr_ready=0) while playing or when the table is full.
module digi_pattern_source #(
    parameter int   DEPTH = 8,
    parameter int   DUR_W = 16,
    parameter logic INIT  = 1'b0
) (
    input logic                  clk,
    input logic                  rst_n,
    digi_pattern_source_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [DUR_W-1:0] rem_q,   rem_d;
    logic             dout_q,  dout_d;
    logic             edge_q,  edge_d;
    logic             rep_q,   rep_d;

    logic             lvl_q [DEPTH];
    logic [DUR_W-1:0] dur_q [DEPTH];

    logic             wr_ready;
    logic             wr_fire;
    logic             start_ok;
    logic [IW-1:0]    last_idx;
    logic [IW-1:0]    next_idx;

    // A zero duration still holds its level for one cycle.
    function automatic logic [DUR_W-1:0] eff_dur(input logic [DUR_W-1:0] d);
        return (d == '0) ? DUR_W'(1) : d;
    endfunction

    assign wr_ready = (state_q != S_RUN) && (count_q < CW'(DEPTH));
    assign wr_fire  = bus.wr_valid && wr_ready && !bus.clear;
    // clear also blocks start so RUN never sees an empty table
    assign start_ok = bus.start && !bus.stop && !bus.clear && (count_q != '0);
    assign last_idx = IW'(count_q - CW'(1));
    assign next_idx = (idx_q == last_idx) ? '0 : idx_q + IW'(1);

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        idx_d   = idx_q;
        rem_d   = rem_q;
        dout_d  = dout_q;
        rep_d   = rep_q;

        if (wr_fire) begin
            count_d = count_q + CW'(1);
        end

        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (bus.clear) begin
                    count_d = '0;
                end
                if (start_ok) begin
                    state_d = S_RUN;
                    idx_d   = '0;
                    rem_d   = eff_dur(dur_q[0]);
                    dout_d  = lvl_q[0];
                    rep_d   = bus.repeat_en;
                end else if (state_q == S_DONE && (bus.clear || bus.stop)) begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (bus.stop) begin
                    state_d = S_IDLE;
                    dout_d  = INIT;
                end else if (rem_q == DUR_W'(1)) begin
                    if (idx_q == last_idx && !rep_q) begin
                        state_d = S_DONE;
                        dout_d  = INIT;
                    end else begin
                        idx_d  = next_idx;
                        rem_d  = eff_dur(dur_q[next_idx]);
                        dout_d = lvl_q[next_idx];
                    end
                end else begin
                    rem_d = rem_q - DUR_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                dout_d  = INIT;
            end
        endcase

        edge_d = (dout_d != dout_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            idx_q   <= '0;
            rem_q   <= DUR_W'(1);
            dout_q  <= INIT;
            edge_q  <= 1'b0;
            rep_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            idx_q   <= idx_d;
            rem_q   <= rem_d;
            dout_q  <= dout_d;
            edge_q  <= edge_d;
            rep_q   <= rep_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                lvl_q[i] <= INIT;
                dur_q[i] <= '0;
            end
        end else if (wr_fire) begin
            lvl_q[count_q[IW-1:0]] <= bus.wr_level;
            dur_q[count_q[IW-1:0]] <= bus.wr_dur;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.dout     = dout_q;
    assign bus.edge_o   = edge_q;
    assign bus.busy     = (state_q == S_RUN);
    assign bus.done     = (state_q == S_DONE);
    assign bus.count    = count_q;
endmodule
